// File: rtl/can_acf_filter_sequencer_if.sv
// CAN acceptance-filter sequencer bus bundle.
// Frame input, filter table port, RX FIFO port and status.
interface can_acf_filter_sequencer_if #(
  parameter int IDX_W = 2
);
  logic             i_frame_ready;
  logic [28:0]      i_rx_id;
  logic             i_rx_ide;
  logic [IDX_W-1:0] o_flt_addr;
  logic [28:0]      i_flt_id;
  logic [28:0]      i_flt_mask;
  logic             i_flt_ide;
  logic             i_flt_en;
  logic             i_fifo_full;
  logic             o_fifo_wr;
  logic [29+IDX_W:0] o_fifo_data;
  logic             o_accept;
  logic             o_reject;
  logic             o_overrun;
  logic             o_busy;

  modport master (
    input  i_frame_ready,
    input  i_rx_id,
    input  i_rx_ide,
    output o_flt_addr,
    input  i_flt_id,
    input  i_flt_mask,
    input  i_flt_ide,
    input  i_flt_en,
    input  i_fifo_full,
    output o_fifo_wr,
    output o_fifo_data,
    output o_accept,
    output o_reject,
    output o_overrun,
    output o_busy
  );

  modport slave (
    output i_frame_ready,
    output i_rx_id,
    output i_rx_ide,
    input  o_flt_addr,
    output i_flt_id,
    output i_flt_mask,
    output i_flt_ide,
    output i_flt_en,
    output i_fifo_full,
    input  o_fifo_wr,
    input  o_fifo_data,
    input  o_accept,
    input  o_reject,
    input  o_overrun,
    input  o_busy
  );
endinterface

// File: rtl/can_acf_filter_sequencer.sv
// CAN acceptance-filter sequencer: walks the filter table per frame.
// Optional overrun counter: define CAN_ACF_OVERRUN_CNT_EN.
module can_acf_filter_sequencer #(
  parameter int NUM_FILTERS = 4,
  parameter int IDX_W =
    (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic i_sys_clk,
  input  logic i_reset,
`ifdef CAN_ACF_OVERRUN_CNT_EN
  input  logic       i_cnt_clr,
  output logic [7:0] o_overrun_cnt,
`endif
  can_acf_filter_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_WRITE,
    S_REJECT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ADDR =
    IDX_W'(NUM_FILTERS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [28:0]      lat_id;
  logic             lat_ide;
  logic [IDX_W-1:0] addr;
  logic [IDX_W-1:0] hit_idx;
  logic             ovr_pend;

  logic [28:0] eff;
  logic        hit;
  logic        last;
  logic        fifo_wr;
  logic        accept;
  logic        reject;
  logic        ovr_full;
  logic        busy;
  logic        overrun;

  // Standard frames only compare the low 11 bits.
  assign eff  = lat_ide ? '1 : 29'h7FF;
  assign last = (addr == LAST_ADDR);
  assign hit  = bus.i_flt_en
             && (bus.i_flt_ide == lat_ide)
             && (((lat_id ^ bus.i_flt_id)
                  & bus.i_flt_mask & eff) == '0);

  // State register.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and state-decoded strobes.
  always_comb begin
    state_nxt = state;
    fifo_wr   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    ovr_full  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.i_frame_ready) state_nxt = S_READ;
      end
      S_READ: state_nxt = S_CMP;
      S_CMP: begin
        if (hit)       state_nxt = S_WRITE;
        else if (last) state_nxt = S_REJECT;
        else           state_nxt = S_READ;
      end
      S_WRITE: begin
        fifo_wr   = ~bus.i_fifo_full;
        accept    = ~bus.i_fifo_full;
        ovr_full  = bus.i_fifo_full;
        state_nxt = S_IDLE;
      end
      S_REJECT: begin
        reject    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame latch, scan address, hit index, busy-overrun flag.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      lat_id   <= '0;
      lat_ide  <= 1'b0;
      addr     <= '0;
      hit_idx  <= '0;
      ovr_pend <= 1'b0;
    end else begin
      ovr_pend <= bus.i_frame_ready
               && (state != S_IDLE);
      if (state == S_IDLE && bus.i_frame_ready) begin
        lat_id  <= bus.i_rx_id;
        lat_ide <= bus.i_rx_ide;
        addr    <= '0;
      end
      if (state == S_CMP) begin
        if (hit)        hit_idx <= addr;
        else if (!last) addr <= addr + IDX_W'(1);
      end
      if (state == S_WRITE || state == S_REJECT)
        addr <= '0;
    end
  end

  // Both overrun sources collapse into one pulse.
  assign overrun = ovr_pend | ovr_full;

  assign bus.o_flt_addr  = addr;
  assign bus.o_fifo_wr   = fifo_wr;
  assign bus.o_fifo_data = fifo_wr
    ? {hit_idx, lat_ide, lat_id} : '0;
  assign bus.o_accept    = accept;
  assign bus.o_reject    = reject;
  assign bus.o_overrun   = overrun;
  assign bus.o_busy      = busy;

`ifdef CAN_ACF_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;

  // Saturating overrun counter; clear beats increment.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset)
      ovr_cnt <= '0;
    else if (i_cnt_clr)
      ovr_cnt <= '0;
    else if (overrun && ovr_cnt != 8'hFF)
      ovr_cnt <= ovr_cnt + 8'd1;
  end

  assign o_overrun_cnt = ovr_cnt;
`endif

endmodule

// File: tb/tb_can_acf_filter_sequencer.sv
// Bench for can_acf_filter_sequencer (directed + random frames).
// Honors CAN_ACF_OVERRUN_CNT_EN when defined.
module tb_can_acf_filter_sequencer;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  can_acf_filter_sequencer_if #(.IDX_W(IW)) bus();

`ifdef CAN_ACF_OVERRUN_CNT_EN
  logic       cnt_clr;
  logic [7:0] ovr_cnt;
`endif

  can_acf_filter_sequencer #(
    .NUM_FILTERS(N),
    .IDX_W(IW)
  ) dut (
    .i_sys_clk(clk),
    .i_reset(rst),
`ifdef CAN_ACF_OVERRUN_CNT_EN
    .i_cnt_clr(cnt_clr),
    .o_overrun_cnt(ovr_cnt),
`endif
    .bus(bus)
  );

  logic [28:0] t_id   [N];
  logic [28:0] t_mask [N];
  logic        t_ide  [N];
  logic        t_en   [N];

  int total = 0;
  int bad   = 0;

  // Filter table with one-cycle registered read.
  always @(posedge clk) begin
    bus.i_flt_id   <= t_id[bus.o_flt_addr];
    bus.i_flt_mask <= t_mask[bus.o_flt_addr];
    bus.i_flt_ide  <= t_ide[bus.o_flt_addr];
    bus.i_flt_en   <= t_en[bus.o_flt_addr];
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int ref_match(input logic [28:0] id,
                                   input logic ide);
    logic [28:0] care;
    for (int i = 0; i < N; i++) begin
      care = t_mask[i] & (ide ? 29'h1FFFFFFF : 29'h7FF);
      if (t_en[i] && t_ide[i] == ide &&
          ((id & care) == (t_id[i] & care)))
        return i;
    end
    return -1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "/busy"},    64'(bus.o_busy),      64'd0);
    chk({tag, "/addr"},    64'(bus.o_flt_addr),  64'd0);
    chk({tag, "/wr"},      64'(bus.o_fifo_wr),   64'd0);
    chk({tag, "/data"},    64'(bus.o_fifo_data), 64'd0);
    chk({tag, "/accept"},  64'(bus.o_accept),    64'd0);
    chk({tag, "/reject"},  64'(bus.o_reject),    64'd0);
    chk({tag, "/overrun"}, 64'(bus.o_overrun),   64'd0);
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      t_id[i] = '0; t_mask[i] = '0;
      t_ide[i] = 1'b0; t_en[i] = 1'b0;
    end
  endtask

  // Called at a negedge with the DUT idle; inj=0 means
  // no extra frame, else a frame pulse in cycle inj.
  task automatic run_frame(input logic [28:0] id,
                           input logic ide,
                           input logic full,
                           input int inj,
                           input string tag);
    int k, fin;
    logic hit, e_wr, e_ovr;
    logic [IW-1:0] ki;
    logic [31:0] e_data;
    int e_addr;
    string s;
    k   = ref_match(id, ide);
    hit = (k >= 0);
    fin = hit ? 3 + 2 * k : 2 * N + 1;
    ki  = hit ? IW'(k) : '0;
    bus.i_fifo_full   = full;
    bus.i_rx_id       = id;
    bus.i_rx_ide      = ide;
    bus.i_frame_ready = 1'b1;
    for (int c = 1; c <= fin + 1; c++) begin
      @(negedge clk);
      s      = $sformatf("%s@%0d", tag, c);
      e_wr   = hit && !full && c == fin;
      e_ovr  = (inj > 0 && c == inj + 1) ||
               (hit && full && c == fin);
      e_data = e_wr ? {ki, ide, id} : 32'd0;
      chk({s, "/busy"}, 64'(bus.o_busy),
          64'(c <= fin));
      chk({s, "/wr"}, 64'(bus.o_fifo_wr), 64'(e_wr));
      chk({s, "/accept"}, 64'(bus.o_accept), 64'(e_wr));
      chk({s, "/reject"}, 64'(bus.o_reject),
          64'(!hit && c == fin));
      chk({s, "/overrun"}, 64'(bus.o_overrun),
          64'(e_ovr));
      chk({s, "/data"}, 64'(bus.o_fifo_data),
          64'(e_data));
      if (c <= fin) begin
        if (c == fin) e_addr = hit ? k : N - 1;
        else          e_addr = (c - 1) / 2;
        chk({s, "/addr"}, 64'(bus.o_flt_addr),
            64'(e_addr));
      end
      bus.i_frame_ready = (c == inj);
      if (c == inj) begin
        bus.i_rx_id  = ~id;
        bus.i_rx_ide = ~ide;
      end
    end
    bus.i_frame_ready = 1'b0;
  endtask

  logic [28:0] rid;
  logic        ride, rfull;
  int          rk, rfin, rinj, rj;

  initial begin
    rst               = 1'b1;
    bus.i_frame_ready = 1'b0;
    bus.i_rx_id       = '0;
    bus.i_rx_ide      = 1'b0;
    bus.i_fifo_full   = 1'b0;
`ifdef CAN_ACF_OVERRUN_CNT_EN
    cnt_clr = 1'b0;
`endif
    clear_table();
    @(negedge clk);
    chk_quiet("reset");
`ifdef CAN_ACF_OVERRUN_CNT_EN
    chk("reset/cnt", 64'(ovr_cnt), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("idle");

    t_en[2] = 1'b1; t_ide[2] = 1'b0;
    t_id[2] = 29'h123; t_mask[2] = 29'h7FF;
    run_frame(29'h123, 1'b0, 1'b0, 0, "std_hit2");
    run_frame(29'h055, 1'b0, 1'b0, 0, "std_reject");
    run_frame(29'h1FFFF123, 1'b0, 1'b0, 0, "std_upper");
    run_frame(29'h123, 1'b0, 1'b0, 4, "busy_ovr");
    run_frame(29'h123, 1'b0, 1'b1, 0, "full_ovr");
    run_frame(29'h123, 1'b0, 1'b1, 6, "dual_ovr");
    run_frame(29'h123, 1'b0, 1'b0, 7, "exit_ovr");

    clear_table();
    t_en[0] = 1'b1; t_ide[0] = 1'b1;
    t_id[0] = 29'h1ABCDE00; t_mask[0] = 29'h1FFFFF00;
    t_en[3] = 1'b1; t_ide[3] = 1'b1;
    t_id[3] = 29'h1ABCDE00; t_mask[3] = 29'h1FFFFF00;
    run_frame(29'h1ABCDE00, 1'b1, 1'b0, 0, "ext_first");
    run_frame(29'h1ABCDE00, 1'b0, 1'b0, 0, "ide_mis");

    clear_table();
    t_en[2] = 1'b1; t_ide[2] = 1'b0;
    t_id[2] = 29'h123; t_mask[2] = 29'h7FF;
    bus.i_rx_id       = 29'h123;
    bus.i_rx_ide      = 1'b0;
    bus.i_frame_ready = 1'b1;
    @(negedge clk);
    bus.i_frame_ready = 1'b0;
    @(negedge clk);
    chk("rst_cmp/busy", 64'(bus.o_busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_quiet("rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("rst_after");
    run_frame(29'h123, 1'b0, 1'b0, 0, "post_rst");

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        t_en[i]   = ($urandom_range(0, 3) != 0);
        t_ide[i]  = 1'($urandom_range(0, 1));
        t_mask[i] = 29'($urandom & $urandom & $urandom);
        t_id[i]   = 29'($urandom);
      end
      rid  = 29'($urandom);
      ride = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        rj = $urandom_range(0, N - 1);
        t_id[rj]  = rid ^ (29'($urandom) & ~t_mask[rj]);
        t_ide[rj] = ride;
      end
      rfull = ($urandom_range(0, 3) == 0);
      rk    = ref_match(rid, ride);
      rfin  = (rk >= 0) ? 3 + 2 * rk : 2 * N + 1;
      rinj  = ($urandom_range(0, 2) == 0)
            ? $urandom_range(1, rfin) : 0;
      run_frame(rid, ride, rfull, rinj,
                $sformatf("rnd%0d", it));
    end

`ifdef CAN_ACF_OVERRUN_CNT_EN
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt/clr0", 64'(ovr_cnt), 64'd0);
    clear_table();
    t_en[0] = 1'b1;
    for (int i = 0; i < 260; i++) begin
      run_frame(29'($urandom_range(0, 2047)), 1'b0,
                1'b1, 0, "cnt_run");
      if (i == 199) begin
        @(negedge clk);
        chk("cnt/200", 64'(ovr_cnt), 64'd200);
      end
    end
    @(negedge clk);
    chk("cnt/sat", 64'(ovr_cnt), 64'd255);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt/clr", 64'(ovr_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_acf_filter_sequencer.md
# can_acf_filter_sequencer

Acceptance-filter sequencer in the SYS_CLK domain of the CAN controller. On each synchronized frame-ready pulse it latches the received identifier and walks an external filter table one entry at a time. It compares the identifier against each entry's ID/mask pair. A frame that hits is pushed into the RX FIFO tagged with the index of the first matching filter; otherwise the frame is rejected.

## Interface
Parameters:
- NUM_FILTERS, 4, number of filter table entries; legal range 1..32.
- IDX_W, $clog2(NUM_FILTERS) (minimum 1), width of the filter index.

Ports:
- i_sys_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_frame_ready  in  1  one-cycle pulse, already synchronized into i_sys_clk: a new frame is available.
- i_rx_id  in  29  received identifier. Extended uses [28:0]; standard is right-justified in [10:0].
- i_rx_ide  in  1  1 = extended frame, 0 = standard.
- o_flt_addr  out  IDX_W  filter table read address.
- i_flt_id  in  29  filter ID at the address presented the previous cycle.
- i_flt_mask  in  29  filter mask; 1 = compare bit, 0 = don't care.
- i_flt_ide  in  1  frame type the filter accepts.
- i_flt_en  in  1  entry enable.
- i_fifo_full  in  1  RX FIFO full.
- o_fifo_wr  out  1  FIFO write strobe, one cycle.
- o_fifo_data  out  30+IDX_W  {match index, ide, id}, valid while o_fifo_wr = 1.
- o_accept  out  1  one-cycle pulse: frame written to the FIFO.
- o_reject  out  1  one-cycle pulse: no filter matched.
- o_overrun  out  1  one-cycle pulse: frame lost, because the block was busy or the FIFO was full.
- o_busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, READ, CMP, WRITE, REJECT. Outputs are decoded from registered state only.
- IDLE:
  - On i_frame_ready, latch i_rx_id/i_rx_ide into internal registers, clear the address to 0, go to READ.
- READ:
  - Drive o_flt_addr = current address (o_flt_addr holds this value through CMP).
  - Go to CMP.
- CMP:
  - Hit when all three hold: i_flt_en = 1; i_flt_ide == latched ide; ((latched_id ^ i_flt_id) & i_flt_mask & eff) == 0.
  - eff = all ones when ide = 1; 29'h7FF when ide = 0, so upper bits are ignored for standard frames.
  - On a hit, record the index and go to WRITE.
  - On a miss at address NUM_FILTERS-1, go to REJECT.
  - On any other miss, increment the address and go to READ.
- WRITE:
  - If i_fifo_full = 0: assert o_fifo_wr and o_accept.
  - If i_fifo_full = 1: drop the frame and assert o_overrun.
  - Go to IDLE in either case.
- REJECT: assert o_reject, go to IDLE.
- Lowest index wins. Scanning stops at the first hit; later entries are not read.
- i_frame_ready in any state other than IDLE, including the WRITE/REJECT exit cycle: the frame is ignored, o_overrun pulses the next cycle, and the in-progress frame is unaffected.
- A simultaneous busy-overrun and FIFO-full overrun produce a single o_overrun pulse.
- Reset (asynchronous, any state):
  - State → IDLE; latched registers and address → 0.
  - o_flt_addr = 0, o_fifo_wr = 0, o_fifo_data = 0, o_accept = 0, o_reject = 0, o_overrun = 0, o_busy = 0.
  - A frame in progress is discarded with no pulse.

## Timing
- Cycle 0 is the cycle i_frame_ready is sampled high in IDLE.
- Filter k is addressed in cycle 1+2k and compared in cycle 2+2k.
- Hit on filter k: o_fifo_wr/o_accept high in cycle 3+2k. Earliest is cycle 3.
- All entries miss: o_reject high in cycle 2N+1.
- o_busy is high from cycle 1 through the WRITE/REJECT cycle inclusive.
- Next acceptable i_frame_ready: the cycle after WRITE/REJECT.
- Table read latency is exactly 1 cycle. The table must return data for the o_flt_addr presented in the previous cycle.

## Configuration
- CAN_ACF_OVERRUN_CNT_EN defined:
  - Adds input i_cnt_clr (1 bit) and output o_overrun_cnt (8 bits).
  - o_overrun_cnt increments on each o_overrun pulse and saturates at 255.
  - i_cnt_clr synchronously clears it; clear wins over a simultaneous increment.
  - Reset value 0.
- Not defined: neither port exists, no counter logic is present, and all other behaviour is identical.

## Test plan
- NUM_FILTERS=4, filter 2 = {ide=0, id=11'h123, mask=11'h7FF, en=1}, others disabled; frame std 0x123 → o_fifo_wr at cycle 7 with index 2, o_accept pulse, o_busy low at cycle 8.
- Filters 0 and 3 both match ext id 0x1ABCDE00 (mask 0x1FFFFF00) → accepted with index 0 at cycle 3; address 1..3 never driven.
- No entry matches std 0x055 → o_reject at cycle 9; no o_fifo_wr.
- Second i_frame_ready at cycle 4 of a 4-filter scan → o_overrun pulse at cycle 5; the first frame still completes.
- Match while i_fifo_full=1 → o_overrun, no o_fifo_wr, no o_accept. With CAN_ACF_OVERRUN_CNT_EN: 256 overruns → o_overrun_cnt=255, then i_cnt_clr → 0.
- Assert i_reset during CMP → all outputs 0 immediately; a new frame after reset release is scanned from address 0.
